// File: rtl/stage_chain_pkg.sv
// stage_chain_pkg
// Shared types and arithmetic helper for the stage_chain_counter block.
//   mode_e   : output presentation mode (registered chain vs. combinational view).
//   step_add : bounded add used by every stage: wrap modulo 2^width or clamp
//              at 2^width-1, with a carry-preserving intermediate.
package stage_chain_pkg;

    typedef enum logic {
        MODE_PIPE = 1'b0,
        MODE_COMB = 1'b1
    } mode_e;

    // Widths up to 31 bits are supported; the 33-bit intermediate never loses the carry.
    function automatic logic [31:0] step_add(
        input logic [31:0] value,
        input logic [31:0] step,
        input int unsigned width,
        input logic        sat
    );
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, value} + {1'b0, step};
        max = (33'd1 << width) - 33'd1;
        if (sum > max) begin
            return sat ? max[31:0] : (sum[31:0] & max[31:0]);
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/stage_chain_cell.sv
// stage_chain_cell
// One registered stage of the chain plus its valid bit.
// Ports:
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   adv_i           : capture d_i / v_in_i this edge
//   clr_valid_i     : force the captured valid bit to 0 (load restarts the valid wave)
//   d_i             : next stage value (already stepped by the caller)
//   v_in_i          : valid bit of the previous stage
//   q_o, v_o        : registered stage value and valid
module stage_chain_cell #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             adv_i,
    input  logic             clr_valid_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             v_in_i,
    output logic [WIDTH-1:0] q_o,
    output logic             v_o
);

    logic [WIDTH-1:0] r_q;
    logic             r_v;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_q <= '0;
            r_v <= 1'b0;
        end else if (adv_i) begin
            r_q <= d_i;
            r_v <= clr_valid_i ? 1'b0 : v_in_i;
        end
    end

    assign q_o = r_q;
    assign v_o = r_v;

endmodule

// File: rtl/stage_chain_counter.sv
// stage_chain_counter
// Chain of STAGES counter stages: stage 0 is a loadable counter, stage k registers
// stage k-1 plus STEP. Wrap or saturate arithmetic, per-stage valid, overflow pulse.
// Ports:
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   en_i            : advance the chain
//   load_i          : load stage 0 from load_val_i (also advances; wins over en_i)
//   load_val_i      : value for stage 0
//   mode_i          : MODE_PIPE shows registers, MODE_COMB shows s0 + k*STEP directly
//   stage_o         : stage values
//   valid_o         : per-stage valid
//   overflow_o      : registered one-cycle pulse on stage-0 carry-out
module stage_chain_counter
    import stage_chain_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned STAGES   = 3,
    parameter int unsigned STEP     = 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic                           en_i,
    input  logic                           load_i,
    input  logic [WIDTH-1:0]               load_val_i,
    input  mode_e                          mode_i,
    output logic [STAGES-1:0][WIDTH-1:0]   stage_o,
    output logic [STAGES-1:0]              valid_o,
    output logic                           overflow_o
);

    logic             w_adv;
    logic [WIDTH-1:0] r_s0;
    logic             r_v0;
    logic             r_ovf;
    logic [WIDTH:0]   w_sum0;
    logic [WIDTH-1:0] w_s0_next;

    logic [WIDTH-1:0] w_s    [STAGES];
    logic             w_v    [STAGES];
    logic [WIDTH-1:0] w_comb [STAGES];

    assign w_adv     = en_i | load_i;
    assign w_sum0    = {1'b0, r_s0} + (WIDTH+1)'(STEP);
    assign w_s0_next = WIDTH'(step_add(32'(r_s0), 32'(STEP), WIDTH, SATURATE));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_s0  <= '0;
            r_v0  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_s0  <= load_i ? load_val_i : w_s0_next;
            r_v0  <= 1'b1;
            // Carry-out also fires while saturated at max, so ovf stays high there.
            r_ovf <= ~load_i & w_sum0[WIDTH];
        end else begin
            r_ovf <= 1'b0;
        end
    end

    assign w_s[0] = r_s0;
    assign w_v[0] = r_v0;

    for (genvar k = 1; k < STAGES; k++) begin : g_cell
        logic [WIDTH-1:0] w_d;
        assign w_d = WIDTH'(step_add(32'(w_s[k-1]), 32'(STEP), WIDTH, SATURATE));

        stage_chain_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk_i      (clk_i),
            .reset_ni   (reset_ni),
            .adv_i      (w_adv),
            .clr_valid_i(load_i),
            .d_i        (w_d),
            .v_in_i     (w_v[k-1]),
            .q_o        (w_s[k]),
            .v_o        (w_v[k])
        );
    end

    // Combinational view: every stage derived from s0 alone, no dependence on en/load.
    for (genvar k = 0; k < STAGES; k++) begin : g_comb
        assign w_comb[k] = WIDTH'(step_add(32'(r_s0), 32'(k * STEP), WIDTH, SATURATE));
    end

    always_comb begin
        stage_o = '0;
        valid_o = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (mode_i == MODE_COMB) begin
                stage_o[k] = w_comb[k];
                valid_o[k] = r_v0;
            end else begin
                stage_o[k] = w_s[k];
                valid_o[k] = w_v[k];
            end
        end
    end

    assign overflow_o = r_ovf;

endmodule
